phase_sequencer: RTL and testbench

Parametrised multi-phase timed sequencer, the generalised successor to the fixed four-state coffee-machine controller. It steps through `NUM_PHASES` phases. Each phase lasts a per-phase number of `dividedclk` ticks, and the sequence runs either continuously (loop) or once per start request (one-shot). It adds pause, phase skip, one-shot operation and completion strobes. It exports one-hot phase, phase index and elapsed/remaining counts, which feed the LED and seven-segment display logic directly.

---
 rtl/phase_seq_pkg.sv | 18 +
 rtl/phase_sequencer_timer.sv | 26 ++
 rtl/phase_sequencer.sv | 105 ++++++++++
 tb/tb_phase_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared types, default coffee-cycle durations and duration helper for the phase sequencer.
package phase_seq_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  localparam int unsigned DUR_BREW  = 5;
  localparam int unsigned DUR_STEAM = 3;
  localparam int unsigned DUR_WAIT  = 10;
  localparam int unsigned DUR_CLEAN = 4;

  // A programmed duration of zero still occupies one tick.
  function automatic int unsigned eff_dur(input int unsigned field);
    return (field == 32'd0) ? 32'd1 : field;
  endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Per-phase tick counter with clear/enable and terminal-count compare against the phase duration.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             dividedclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] elapsed,
  output logic             tc
);

  always_ff @(posedge dividedclk or posedge reset) begin
    if (reset)
      elapsed <= '0;
    else if (clr)
      elapsed <= '0;
    else if (inc)
      elapsed <= elapsed + CNT_W'(1);
  end

  // d is always at least 1, so d-1 cannot underflow.
  assign tc = (elapsed == d - CNT_W'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase timed sequencer: loop or one-shot runs through NUM_PHASES timed phases,
// with pause, skip and phase/cycle completion strobes for the LED and display logic.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 4,
  parameter int PHASE_W    = $clog2(NUM_PHASES),
  parameter logic [NUM_PHASES*CNT_W-1:0] DURATIONS =
    {4'(DUR_CLEAN), 4'(DUR_WAIT), 4'(DUR_STEAM), 4'(DUR_BREW)}
) (
  input  logic                  reset,
  input  logic                  dividedclk,
  input  logic                  en,
  input  logic                  mode_loop,
  input  logic                  start,
  input  logic                  skip,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic [CNT_W-1:0]      elapsed,
  output logic [CNT_W-1:0]      remaining,
  output logic                  busy,
  output logic                  phase_done,
  output logic                  cycle_done
);

  state_t             state_q;
  logic [PHASE_W-1:0] phase_idx_q;
  logic [CNT_W-1:0]   d_cur;
  logic [CNT_W-1:0]   elapsed_w;
  logic               tc;
  logic               busy_w;
  logic               last_phase;
  logic               phase_end;
  logic               tmr_clr;
  logic               tmr_inc;

  // Effective duration of the current phase
  always_comb begin
    d_cur = CNT_W'(1);
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_idx_q == PHASE_W'(i))
        d_cur = CNT_W'(eff_dur(32'(DURATIONS[i*CNT_W +: CNT_W])));
    end
  end

  assign busy_w     = (state_q == ST_RUN);
  assign last_phase = (phase_idx_q == PHASE_W'(NUM_PHASES - 1));
  // Skip and terminal count together collapse into one phase end.
  assign phase_end  = busy_w & en & (tc | skip);

  // Counter restarts on every phase entry; in IDLE it is held at zero.
  assign tmr_clr = en & (~busy_w | phase_end);
  assign tmr_inc = en & busy_w & ~phase_end;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .dividedclk (dividedclk),
    .reset      (reset),
    .clr        (tmr_clr),
    .inc        (tmr_inc),
    .d          (d_cur),
    .elapsed    (elapsed_w),
    .tc         (tc)
  );

  // FSM and phase index
  always_ff @(posedge dividedclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_idx_q <= '0;
    end else if (en) begin
      if (state_q == ST_IDLE) begin
        if (start | mode_loop) begin
          state_q     <= ST_RUN;
          phase_idx_q <= '0;
        end
      end else if (phase_end) begin
        if (!last_phase) begin
          phase_idx_q <= phase_idx_q + PHASE_W'(1);
        end else begin
          phase_idx_q <= '0;
          if (!mode_loop)
            state_q <= ST_IDLE;
        end
      end
    end
  end

  // Output decode
  always_comb begin
    phase_onehot = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      phase_onehot[i] = busy_w & (phase_idx_q == PHASE_W'(i));
  end

  assign phase_idx  = phase_idx_q;
  assign elapsed    = elapsed_w;
  assign remaining  = busy_w ? (d_cur - elapsed_w) : '0;
  assign busy       = busy_w;
  assign phase_done = phase_end;
  assign cycle_done = phase_end & last_phase;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default coffee durations plus a variant with a zero-length phase 1.
module tb_phase_sequencer;

  logic       reset, dividedclk, en, mode_loop, start, skip;
  logic [3:0] phase_onehot, z_onehot;
  logic [1:0] phase_idx, z_idx;
  logic [3:0] elapsed, z_elapsed, remaining, z_remaining;
  logic       busy, z_busy, phase_done, z_phase_done, cycle_done, z_cycle_done;

  int n_tests = 0;
  int n_fail  = 0;

  phase_sequencer dut (
    .reset(reset), .dividedclk(dividedclk), .en(en), .mode_loop(mode_loop),
    .start(start), .skip(skip), .phase_onehot(phase_onehot), .phase_idx(phase_idx),
    .elapsed(elapsed), .remaining(remaining), .busy(busy),
    .phase_done(phase_done), .cycle_done(cycle_done)
  );

  phase_sequencer #(.DURATIONS({4'd4, 4'd10, 4'd0, 4'd5})) dut_z (
    .reset(reset), .dividedclk(dividedclk), .en(en), .mode_loop(mode_loop),
    .start(start), .skip(skip), .phase_onehot(z_onehot), .phase_idx(z_idx),
    .elapsed(z_elapsed), .remaining(z_remaining), .busy(z_busy),
    .phase_done(z_phase_done), .cycle_done(z_cycle_done)
  );

  initial dividedclk = 1'b0;
  always #5 dividedclk = ~dividedclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge dividedclk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".onehot"},  32'(phase_onehot), 32'd0);
    check({tag, ".idx"},     32'(phase_idx),    32'd0);
    check({tag, ".elapsed"}, 32'(elapsed),      32'd0);
    check({tag, ".remain"},  32'(remaining),    32'd0);
    check({tag, ".busy"},    32'(busy),         32'd0);
    check({tag, ".pdone"},   32'(phase_done),   32'd0);
    check({tag, ".cdone"},   32'(cycle_done),   32'd0);
    check({tag, ".z_busy"},  32'(z_busy),       32'd0);
    check({tag, ".z_onehot"},32'(z_onehot),     32'd0);
  endtask

  task automatic check_pos(input string tag, input int idx, input int el);
    check({tag, ".idx"},     32'(phase_idx), 32'(idx));
    check({tag, ".elapsed"}, 32'(elapsed),   32'(el));
  endtask

  initial begin
    int occ [4];
    int ncd;
    int nb;

    reset = 1'b1; en = 1'b0; mode_loop = 1'b0; start = 1'b0; skip = 1'b0;
    #1;
    check_zero("reset");
    wait_n(2);
    reset = 1'b0;
    wait_n(1);
    check("idle_after_rst.busy", 32'(busy), 32'd0);

    // Loop mode over the default 5/3/10/4 durations
    mode_loop = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) occ[i] = 0;
    ncd = 0;
    for (int s = 1; s <= 22; s++) begin
      wait_n(1);
      occ[phase_idx]++;
      ncd += int'(cycle_done);
      if (s == 1) begin
        check("loop.s1.onehot", 32'(phase_onehot), 32'b0001);
        check("loop.s1.elapsed", 32'(elapsed), 32'd0);
        check("loop.s1.remain", 32'(remaining), 32'd5);
        check("loop.s1.busy", 32'(busy), 32'd1);
      end
      if (s == 6)  check("loop.s6.onehot",  32'(phase_onehot), 32'b0010);
      if (s == 9)  check("loop.s9.onehot",  32'(phase_onehot), 32'b0100);
      if (s == 19) check("loop.s19.onehot", 32'(phase_onehot), 32'b1000);
      if (s == 22) check("loop.s22.cdone",  32'(cycle_done),   32'd1);
    end
    check("loop.occ0", 32'(occ[0]), 32'd5);
    check("loop.occ1", 32'(occ[1]), 32'd3);
    check("loop.occ2", 32'(occ[2]), 32'd10);
    check("loop.occ3", 32'(occ[3]), 32'd4);
    check("loop.ncd", 32'(ncd), 32'd1);
    wait_n(1);
    check("loop.wrap.onehot", 32'(phase_onehot), 32'b0001);
    check("loop.wrap.elapsed", 32'(elapsed), 32'd0);

    // Pause in phase 2 at elapsed 4
    wait_n(12);
    check_pos("pause.pre", 2, 4);
    check("pause.pre.remain", 32'(remaining), 32'd6);
    en = 1'b0; skip = 1'b1;
    #1;
    check("pause.pdone", 32'(phase_done), 32'd0);
    wait_n(7);
    check_pos("pause.hold", 2, 4);
    check("pause.hold.remain", 32'(remaining), 32'd6);
    check("pause.hold.pdone", 32'(phase_done), 32'd0);
    check("pause.hold.cdone", 32'(cycle_done), 32'd0);
    skip = 1'b0; en = 1'b1;
    wait_n(5);
    check_pos("pause.last", 2, 9);
    check("pause.last.pdone", 32'(phase_done), 32'd1);
    wait_n(1);
    check_pos("pause.next", 3, 0);

    // Skip in phase 0 at elapsed 1
    wait_n(4);
    check_pos("skip.p0", 0, 0);
    wait_n(1);
    skip = 1'b1;
    #1;
    check("skip.pdone", 32'(phase_done), 32'd1);
    check("skip.cdone", 32'(cycle_done), 32'd0);
    wait_n(1);
    skip = 1'b0;
    check_pos("skip.after", 1, 0);
    // Skip coinciding with terminal count ends only one phase
    wait_n(2);
    check_pos("skiptc.pre", 1, 2);
    skip = 1'b1;
    #1;
    check("skiptc.pdone", 32'(phase_done), 32'd1);
    wait_n(1);
    skip = 1'b0;
    check_pos("skiptc.after", 2, 0);

    // Leave loop mode; run ends at the next last-phase boundary
    mode_loop = 1'b0;
    wait_n(13);
    check_pos("toidle.last", 3, 3);
    check("toidle.cdone", 32'(cycle_done), 32'd1);
    wait_n(1);
    check_zero("idle");
    wait_n(3);
    check("idle.stay.busy", 32'(busy), 32'd0);
    skip = 1'b1;
    #1;
    check("idle.skip.pdone", 32'(phase_done), 32'd0);
    wait_n(1);
    skip = 1'b0;
    check("idle.skip.busy", 32'(busy), 32'd0);
    check("idle.skip.elapsed", 32'(elapsed), 32'd0);

    // One-shot run with a second start mid-run
    start = 1'b1;
    wait_n(1);
    start = 1'b0;
    check("oneshot.busy", 32'(busy), 32'd1);
    check("oneshot.onehot", 32'(phase_onehot), 32'b0001);
    nb = int'(busy);
    ncd = int'(cycle_done);
    for (int i = 0; i < 30; i++) begin
      start = (i == 8);
      wait_n(1);
      nb += int'(busy);
      ncd += int'(cycle_done);
    end
    start = 1'b0;
    check("oneshot.len", 32'(nb), 32'd22);
    check("oneshot.ncd", 32'(ncd), 32'd1);
    check("oneshot.end.busy", 32'(busy), 32'd0);
    check("oneshot.end.onehot", 32'(phase_onehot), 32'd0);

    // Asynchronous reset in phase 2 at elapsed 7
    mode_loop = 1'b1;
    wait_n(1);
    check_pos("rstrun.p0", 0, 0);
    wait_n(15);
    check_pos("rstrun.pre", 2, 7);
    #2 reset = 1'b1;
    #1;
    check_zero("rstrun.async");
    wait_n(1);
    check_zero("rstrun.held");
    reset = 1'b0;
    wait_n(1);
    check("rstrun.rel.busy", 32'(busy), 32'd1);
    check_pos("rstrun.rel", 0, 0);

    // Zero-length phase 1 in the second instance
    wait_n(4);
    check("zero.p0.idx", 32'(z_idx), 32'd0);
    check("zero.p0.elapsed", 32'(z_elapsed), 32'd4);
    wait_n(1);
    check("zero.p1.idx", 32'(z_idx), 32'd1);
    check("zero.p1.elapsed", 32'(z_elapsed), 32'd0);
    check("zero.p1.remain", 32'(z_remaining), 32'd1);
    check("zero.p1.pdone", 32'(z_phase_done), 32'd1);
    check("zero.p1.onehot", 32'(z_onehot), 32'b0010);
    check("zero.ref.remain", 32'(remaining), 32'd3);
    wait_n(1);
    check("zero.p2.idx", 32'(z_idx), 32'd2);
    check("zero.p2.elapsed", 32'(z_elapsed), 32'd0);
    check("zero.ref.idx", 32'(phase_idx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
